// File: rtl/arm_imm_encoder_if.sv
// Request/result bundle for arm_imm_encoder: start/value in, encoded operand-2 fields out.
interface arm_imm_encoder_if;
    logic        start;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        valid;
    logic [7:0]  imm8;
    logic [3:0]  rot;
    logic [11:0] operand12;
    logic        inverted;
    logic        carry;
    logic        cin_pass;

    modport master (
        output start, value,
        input  busy, done, valid, imm8, rot, operand12, inverted, carry, cin_pass
    );

    modport slave (
        input  start, value,
        output busy, done, valid, imm8, rot, operand12, inverted, carry, cin_pass
    );
endinterface

// File: rtl/arm_imm_encoder.sv
// Finds the canonical ARM rotated immediate {rot, imm8} for a 32-bit value, one rotation per clock.
// Latency r+1 cycles (1..16); start is ignored outside IDLE. ARM_IMM_ENC_INVERT_EN adds the ~value (MVN/BIC) search.
module arm_imm_encoder (
    input  logic              clk,
    input  logic              reset,
    arm_imm_encoder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] val_q;
    logic [3:0]  r;
    logic [31:0] cand_p;
    logic        hit_p;
    logic        hit;
    logic        valid_q;
    logic [7:0]  imm8_q;
    logic [3:0]  rot_q;
    logic        carry_c;

    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] sh);
        return (sh == 5'd0) ? x : ((x << sh) | (x >> (6'd32 - {1'b0, sh})));
    endfunction

    assign cand_p = rol32(val_q, {r, 1'b0});
    assign hit_p  = (cand_p[31:8] == 24'd0);

`ifdef ARM_IMM_ENC_INVERT_EN
    logic [31:0] cand_n;
    logic        hit_n;
    logic        inv_q;
    assign cand_n       = rol32(~val_q, {r, 1'b0});
    assign hit_n        = (cand_n[31:8] == 24'd0);
    assign hit          = hit_p | hit_n;
    assign bus.inverted = inv_q;
`else
    assign hit          = hit_p;
    assign bus.inverted = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SEARCH;
            SEARCH:  if (hit || r == 4'd15) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val_q   <= 32'd0;
            r       <= 4'd0;
            valid_q <= 1'b0;
            imm8_q  <= 8'd0;
            rot_q   <= 4'd0;
`ifdef ARM_IMM_ENC_INVERT_EN
            inv_q   <= 1'b0;
`endif
        end else if (state == IDLE && bus.start) begin
            val_q <= bus.value;
            r     <= 4'd0;
        end else if (state == SEARCH) begin
            // Plain form wins over inverted form at the same rotation.
            if (hit_p) begin
                valid_q <= 1'b1;
                imm8_q  <= cand_p[7:0];
                rot_q   <= r;
`ifdef ARM_IMM_ENC_INVERT_EN
                inv_q   <= 1'b0;
            end else if (hit_n) begin
                valid_q <= 1'b1;
                imm8_q  <= cand_n[7:0];
                rot_q   <= r;
                inv_q   <= 1'b1;
`endif
            end else if (r == 4'd15) begin
                valid_q <= 1'b0;
                imm8_q  <= 8'd0;
                rot_q   <= 4'd0;
`ifdef ARM_IMM_ENC_INVERT_EN
                inv_q   <= 1'b0;
`endif
            end else begin
                r <= r + 4'd1;
            end
        end
    end

    // Bit 31 of ROR(imm8, 2*rot) lands inside imm8 only for rot 1..4, at bit 2*rot-1.
    always_comb begin
        carry_c = 1'b0;
        case (rot_q)
            4'd1:    carry_c = imm8_q[1];
            4'd2:    carry_c = imm8_q[3];
            4'd3:    carry_c = imm8_q[5];
            4'd4:    carry_c = imm8_q[7];
            default: carry_c = 1'b0;
        endcase
    end

    assign bus.busy      = (state == SEARCH);
    assign bus.done      = (state == DONE);
    assign bus.valid     = valid_q;
    assign bus.imm8      = imm8_q;
    assign bus.rot       = rot_q;
    assign bus.operand12 = {rot_q, imm8_q};
    assign bus.carry     = carry_c;
    assign bus.cin_pass  = (rot_q == 4'd0);
endmodule

// File: tb/tb_arm_imm_encoder.sv
// Self-checking bench for arm_imm_encoder: fixed vectors, random values vs a brute-force decoder-inversion model.
module tb_arm_imm_encoder;
    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    arm_imm_encoder_if bus();
    arm_imm_encoder dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [27:0] RESET_RES = {1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 8'd0, 12'd0};

    // Decoder behaviour: ROR(imm8, 2*rot) on a 32-bit word.
    function automatic logic [31:0] decode(input logic [7:0] imm, input int rot);
        logic [63:0] w;
        int s;
        s = 2 * rot;
        w = {56'd0, imm};
        w = (w << (32 - s)) | (w >> s);
        return w[31:0];
    endfunction

    function automatic logic [27:0] mk(input logic inv, input logic [7:0] imm, input int rot);
        logic [31:0] d;
        logic [3:0]  r4;
        d  = decode(imm, rot);
        r4 = 4'(rot);
        return {1'b1, inv, d[31], (rot == 0), r4, imm, r4, imm};
    endfunction

    // Scan every (rot, imm8) pair, smallest rot first; plain before inverted at each rot.
    function automatic logic [27:0] model(input logic [31:0] v, output int lat);
        for (int rt = 0; rt < 16; rt++) begin
            for (int k = 0; k < 256; k++) begin
                if (decode(8'(k), rt) == v) begin
                    lat = rt + 1;
                    return mk(1'b0, 8'(k), rt);
                end
            end
`ifdef ARM_IMM_ENC_INVERT_EN
            for (int k = 0; k < 256; k++) begin
                if (decode(8'(k), rt) == ~v) begin
                    lat = rt + 1;
                    return mk(1'b1, 8'(k), rt);
                end
            end
`endif
        end
        lat = 16;
        return RESET_RES;
    endfunction

    function automatic logic [27:0] obs();
        return {bus.valid, bus.inverted, bus.carry, bus.cin_pass, bus.rot, bus.imm8, bus.operand12};
    endfunction

    // Runs one encode; reports latency, result, busy behaviour and single-cycle done.
    task automatic encode(input logic [31:0] v, output int lat, output logic [27:0] res,
                          output logic busy_ok, output logic pulse_ok);
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = v;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.value = $urandom;
        busy_ok = bus.busy;
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = obs();
        busy_ok = busy_ok & !bus.busy;
        @(posedge clk);
        #1;
        pulse_ok = !bus.done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.value = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else passed++;
        total++; if (obs() !== RESET_RES) $display("FAIL reset_outputs got %h want %h", obs(), RESET_RES); else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_vectors();
        logic [31:0] vals [4]  = '{32'h000000FF, 32'hFF000000, 32'h000003FC, 32'h00000102};
        logic [27:0] exps [4]  = '{{1'b1, 1'b0, 1'b0, 1'b1, 4'd0,  8'hFF, 12'h0FF},
                                   {1'b1, 1'b0, 1'b1, 1'b0, 4'd4,  8'hFF, 12'h4FF},
                                   {1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 8'hFF, 12'hFFF},
                                   RESET_RES};
        int          lats [4]  = '{1, 5, 16, 16};
        int          lat, mlat;
        logic [27:0] res, mexp;
        logic        bok, pok;
        for (int i = 0; i < 4; i++) begin
            encode(vals[i], lat, res, bok, pok);
            total++; if (res !== exps[i]) $display("FAIL vec_result v=%h got %h want %h", vals[i], res, exps[i]); else passed++;
            total++; if (lat !== lats[i]) $display("FAIL vec_latency v=%h got %0d want %0d", vals[i], lat, lats[i]); else passed++;
            total++; if (bok !== 1'b1) $display("FAIL vec_busy v=%h got %b want 1", vals[i], bok); else passed++;
            total++; if (pok !== 1'b1) $display("FAIL vec_done_pulse v=%h got %b want 1", vals[i], pok); else passed++;
        end
        // Result depends on whether the inverted search is built in.
        mexp = model(32'hFFFFFF00, mlat);
        encode(32'hFFFFFF00, lat, res, bok, pok);
        total++; if (res !== mexp) $display("FAIL vec_ffffff00 got %h want %h", res, mexp); else passed++;
        total++; if (lat !== mlat) $display("FAIL vec_ffffff00_latency got %0d want %0d", lat, mlat); else passed++;
    endtask

    task automatic test_random();
        int          lat, mlat;
        logic [27:0] res, mexp;
        logic        bok, pok;
        logic [31:0] v;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(2, 0))
                0:       v = decode(8'($urandom), int'($urandom_range(15, 0)));
                1:       v = ~decode(8'($urandom), int'($urandom_range(15, 0)));
                default: v = $urandom;
            endcase
            mexp = model(v, mlat);
            encode(v, lat, res, bok, pok);
            total++; if (res !== mexp || lat !== mlat)
                $display("FAIL rand v=%h got %h/%0d want %h/%0d", v, res, lat, mexp, mlat);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [27:0] res;
        logic        bok, pok;
        logic [27:0] want = {1'b1, 1'b0, 1'b1, 1'b0, 4'd4, 8'hFF, 12'h4FF};
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 32'hFF000000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 32'h000000FF;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 3;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total++; if (lat !== 5) $display("FAIL b2b_ignored_start_latency got %0d want 5", lat); else passed++;
        total++; if (obs() !== want) $display("FAIL b2b_ignored_start_result got %h want %h", obs(), want); else passed++;
        @(posedge clk);
        #1;
        total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) $display("FAIL b2b_idle got done=%b busy=%b want 0 0", bus.done, bus.busy); else passed++;
        encode(32'h000000FF, lat, res, bok, pok);
        total++; if (lat !== 1 || res !== {1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 8'hFF, 12'h0FF})
            $display("FAIL b2b_next got %h/%0d want %h/1", res, lat, {1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 8'hFF, 12'h0FF});
        else passed++;
    endtask

    task automatic test_reset_mid();
        int          ndone = 0;
        int          lat;
        logic [27:0] res;
        logic        bok, pok;
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 32'h000003FC;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL midreset_busy got %b want 0", bus.busy); else passed++;
        total++; if (obs() !== RESET_RES) $display("FAIL midreset_outputs got %h want %h", obs(), RESET_RES); else passed++;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        total++; if (ndone !== 0) $display("FAIL midreset_no_done got %0d pulses want 0", ndone); else passed++;
        encode(32'hFF000000, lat, res, bok, pok);
        total++; if (lat !== 5 || res !== {1'b1, 1'b0, 1'b1, 1'b0, 4'd4, 8'hFF, 12'h4FF})
            $display("FAIL midreset_recover got %h/%0d want %h/5", res, lat, {1'b1, 1'b0, 1'b1, 1'b0, 4'd4, 8'hFF, 12'h4FF});
        else passed++;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/arm_imm_encoder.md
# arm_imm_encoder

Sequential encoder that finds the ARM data-processing rotated-immediate encoding (`imm8`, `rot`) for a 32-bit constant. It inverts the operand-2 immediate path of the shifter/sign extender, which decodes `{rot, imm8}` as `ROR(imm8, 2*rot)`. It sits beside the simulator's instruction-assembly and test-generation logic. It searches one rotation per clock behind a start/done handshake and reports the encoded 12-bit field or "not encodable".

## Interface
Parameters:
- none

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: request; sampled only in IDLE.
- `value` input 32: constant to encode; captured on the accepted `start` edge.
- `busy` output 1: high in SEARCH.
- `done` output 1: one-cycle pulse; result valid from this cycle.
- `valid` output 1: an encoding was found.
- `imm8` output 8: encoded immediate.
- `rot` output 4: rotate field; the decoder rotates right by 2*`rot`.
- `operand12` output 12: `{rot, imm8}`, i.e. instruction bits [11:0].
- `inverted` output 1: the encoding is of `~value` (MVN/BIC form).
- `carry` output 1: shifter carry-out the decoder will produce. It equals bit 31 of `ROR(imm8, 2*rot)`; 0 when `rot`==0.
- `cin_pass` output 1: high when `rot`==0, meaning the decoder passes Cin through as carry.

## Operation
- States: IDLE, SEARCH, DONE.
- IDLE + `start`=1 -> latch `value` into `val_q`, clear rotation counter `r`=0, go to SEARCH.
- SEARCH, each cycle: compute `cand = ROL(val_q, 2*r)` as a 32-bit rotate, with no widening or truncation of `val_q`.
  - Match if `cand[31:8]`==0.
  - On match: register `imm8`=`cand[7:0]`, `rot`=`r`, `valid`=1, and go to DONE.
  - No match and `r`<15: `r`<=`r`+1.
  - No match and `r`==15: register `valid`=0, `imm8`=0, `rot`=0, `inverted`=0, and go to DONE.
- The smallest matching `r` wins, so the encoding is canonical. `value`==0 gives `rot`=0, `imm8`=0.
- DONE: `done`=1 for exactly one cycle, then return to IDLE. A `start` arriving in DONE is ignored.
- `start` during SEARCH or DONE is ignored. `value` changes after capture have no effect.
- Result outputs (`valid`, `imm8`, `rot`, `operand12`, `inverted`, `carry`, `cin_pass`) are registered and hold until the next completed search.
- `carry` and `cin_pass` are derived from the registered `imm8` and `rot`. An invalid result gives `carry`=0, `cin_pass`=1.
- Reset (asynchronous, any state, including mid-SEARCH):
  - state goes to IDLE and `r`=0.
  - all outputs go to 0, except `cin_pass`=1.
  - no `done` pulse is produced for the aborted search.

## Timing
- `start` accepted at edge N.
- Rotation `r` is evaluated in the cycle after edge N+`r`.
- A match at `r` is registered at edge N+`r`+1. `done` is high from edge N+`r`+1 until edge N+`r`+2.
- Latency from accepting edge to `done` is `r`+1 cycles: minimum 1, maximum 16 (including not-encodable).
- `busy` is high from edge N until the result edge.
- Back-to-back throughput: the next `start` can be accepted at the edge after `done` falls (IDLE).

## Configuration
- `ARM_IMM_ENC_INVERT_EN` defined:
  - Each SEARCH cycle also tests `ROL(~val_q, 2*r)`.
  - At the same `r`, a plain match takes priority over an inverted match.
  - An inverted match sets `inverted`=1. `imm8`, `rot`, `carry` and `cin_pass` then describe the operand of `~value`.
- Not defined:
  - Only the plain form is searched and `inverted` is tied to 0.
  - Latency and state machine are identical in both builds.

## Test plan
- `value`=0x000000FF -> `rot`=0, `imm8`=0xFF, `operand12`=0x0FF, `valid`=1, `cin_pass`=1, `carry`=0; `done` 1 cycle after the start edge.
- `value`=0xFF000000 -> `rot`=4, `imm8`=0xFF, `operand12`=0x4FF, `carry`=1, `cin_pass`=0; `done` 5 cycles after start.
- `value`=0x000003FC -> `rot`=15, `imm8`=0xFF, `carry`=0; `done` 16 cycles after start.
- `value`=0x00000102 (odd-aligned span) -> `valid`=0, `operand12`=0, `inverted`=0; `done` 16 cycles after start.
- `value`=0xFFFFFF00:
  - with `ARM_IMM_ENC_INVERT_EN`: `valid`=1, `inverted`=1, `rot`=0, `imm8`=0xFF, `done` after 1 cycle.
  - without it: `valid`=0, `done` after 16 cycles.
- Second `start` with 0x000000FF issued 3 cycles into a search of 0xFF000000 -> ignored, result `rot`=4. Then assert `reset` mid-search of 0x000003FC at cycle 6 -> `busy`=0 immediately, no `done`, outputs 0 and `cin_pass`=1.
